// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// CNT_W must match the CNT_W of the hazard_ctrl instance using it.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ra1_d;
    logic [4:0]       ra2_d;
    logic             uses_ra1_d;
    logic             uses_ra2_d;
    logic [4:0]       ra1_e;
    logic [4:0]       ra2_e;
    logic [4:0]       write_reg_e;
    logic             reg_write_e;
    logic             mem_to_reg_e;
    logic             branch_taken_e;
    logic [4:0]       write_reg_m;
    logic             reg_write_m;
    logic [4:0]       write_reg_w;
    logic             reg_write_w;
    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             flush_fd;
    logic             flush_de;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ra1_d, ra2_d, uses_ra1_d, uses_ra2_d, ra1_e, ra2_e,
        output write_reg_e, reg_write_e, mem_to_reg_e, branch_taken_e,
        output write_reg_m, reg_write_m, write_reg_w, reg_write_w,
        input  stall_f, stall_d, stall_e, flush_fd, flush_de,
        input  fwd_a_e, fwd_b_e, busy, stall_cnt
    );

    modport slave (
        input  ra1_d, ra2_d, uses_ra1_d, uses_ra2_d, ra1_e, ra2_e,
        input  write_reg_e, reg_write_e, mem_to_reg_e, branch_taken_e,
        input  write_reg_m, reg_write_m, write_reg_w, reg_write_w,
        output stall_f, stall_d, stall_e, flush_fd, flush_de,
        output fwd_a_e, fwd_b_e, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubbles, branch flushes and
// full-pipeline stretch while a multi-cycle load occupies the memory stage.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input logic          i_clk,
    input logic          i_rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned CntW      = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam bit          MultiCyc  = (LOAD_LAT > 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(LOAD_LAT - 1);

    typedef enum logic [0:0] {StIdle, StMemWait} state_e;

    state_e           r_state;
    logic [CntW-1:0]  r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_load_e;
    logic       w_lu;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_stall_e;
    logic       w_flush_fd;
    logic       w_flush_de;
    logic       w_busy;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] ra, input logic wm,
                                           input logic [4:0] rm, input logic ww,
                                           input logic [4:0] rw);
        if (ra != 5'd0 && wm && rm == ra) begin
            return 2'b10;
        end else if (ra != 5'd0 && ww && rw == ra) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign w_load_e = bus.mem_to_reg_e && bus.reg_write_e;
    assign w_lu     = w_load_e && (bus.write_reg_e != 5'd0) &&
                      ((bus.uses_ra1_d && bus.write_reg_e == bus.ra1_d) ||
                       (bus.uses_ra2_d && bus.write_reg_e == bus.ra2_d));

    // Outputs are gated by the async reset so they drop without waiting for an edge.
    always_comb begin
        w_stall_f  = 1'b0;
        w_stall_d  = 1'b0;
        w_stall_e  = 1'b0;
        w_flush_fd = 1'b0;
        w_flush_de = 1'b0;
        w_busy     = 1'b0;
        w_fwd_a    = 2'b00;
        w_fwd_b    = 2'b00;
        if (i_rst_n) begin
            w_fwd_a = fwd_sel(bus.ra1_e, bus.reg_write_m, bus.write_reg_m,
                              bus.reg_write_w, bus.write_reg_w);
            w_fwd_b = fwd_sel(bus.ra2_e, bus.reg_write_m, bus.write_reg_m,
                              bus.reg_write_w, bus.write_reg_w);
            if (r_state == StMemWait) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_busy    = 1'b1;
            end else if (bus.branch_taken_e) begin
                w_flush_fd = 1'b1;
                w_flush_de = 1'b1;
            end else if (w_lu) begin
                w_stall_f  = 1'b1;
                w_stall_d  = 1'b1;
                w_flush_de = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall_d && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (MultiCyc && w_load_e && !w_stall_e) begin
                        r_state <= StMemWait;
                        r_cnt   <= CntLoad;
                    end
                end
                StMemWait: begin
                    if (r_cnt == CntW'(1)) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.stall_f   = w_stall_f;
    assign bus.stall_d   = w_stall_d;
    assign bus.stall_e   = w_stall_e;
    assign bus.flush_fd  = w_flush_fd;
    assign bus.flush_de  = w_flush_de;
    assign bus.fwd_a_e   = w_fwd_a;
    assign bus.fwd_b_e   = w_fwd_b;
    assign bus.busy      = w_busy;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: u_a is single-cycle memory with a 2-bit counter, u_b has a 3-cycle load.
module tb_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [4:0] ra1_d, ra2_d, ra1_e, ra2_e, write_reg_e, write_reg_m, write_reg_w;
    logic       uses_ra1_d, uses_ra2_d, reg_write_e, mem_to_reg_e, branch_taken_e;
    logic       reg_write_m, reg_write_w;

    hazard_ctrl_if #(.CNT_W(2))  if_a ();
    hazard_ctrl_if #(.CNT_W(16)) if_b ();

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(2))  u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));

    assign if_a.ra1_d = ra1_d;               assign if_b.ra1_d = ra1_d;
    assign if_a.ra2_d = ra2_d;               assign if_b.ra2_d = ra2_d;
    assign if_a.uses_ra1_d = uses_ra1_d;     assign if_b.uses_ra1_d = uses_ra1_d;
    assign if_a.uses_ra2_d = uses_ra2_d;     assign if_b.uses_ra2_d = uses_ra2_d;
    assign if_a.ra1_e = ra1_e;               assign if_b.ra1_e = ra1_e;
    assign if_a.ra2_e = ra2_e;               assign if_b.ra2_e = ra2_e;
    assign if_a.write_reg_e = write_reg_e;   assign if_b.write_reg_e = write_reg_e;
    assign if_a.reg_write_e = reg_write_e;   assign if_b.reg_write_e = reg_write_e;
    assign if_a.mem_to_reg_e = mem_to_reg_e; assign if_b.mem_to_reg_e = mem_to_reg_e;
    assign if_a.branch_taken_e = branch_taken_e;
    assign if_b.branch_taken_e = branch_taken_e;
    assign if_a.write_reg_m = write_reg_m;   assign if_b.write_reg_m = write_reg_m;
    assign if_a.reg_write_m = reg_write_m;   assign if_b.reg_write_m = reg_write_m;
    assign if_a.write_reg_w = write_reg_w;   assign if_b.write_reg_w = write_reg_w;
    assign if_a.reg_write_w = reg_write_w;   assign if_b.reg_write_w = reg_write_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ra1_d = 0; ra2_d = 0; uses_ra1_d = 0; uses_ra2_d = 0;
        ra1_e = 0; ra2_e = 0; write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0;
        branch_taken_e = 0; write_reg_m = 0; reg_write_m = 0; write_reg_w = 0;
        reg_write_w = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr();
        rst_n = 1'b0;
        // Forwarding match and branch present during reset: all must stay 0.
        reg_write_m = 1; write_reg_m = 5; ra1_e = 5; branch_taken_e = 1;
        #2;
        chk("rst_fwd_a", 32'(if_a.fwd_a_e), 32'd0);
        chk("rst_flush_fd", 32'(if_a.flush_fd), 32'd0);
        chk("rst_busy_b", 32'(if_b.busy), 32'd0);
        chk("rst_cnt_a", 32'(if_a.stall_cnt), 32'd0);
        chk("rst_stall_f", 32'(if_b.stall_f), 32'd0);
        #6;
        rst_n = 1'b1;
        clr();

        // Forwarding priority and register 0 exclusion.
        reg_write_m = 1; write_reg_m = 5; reg_write_w = 1; write_reg_w = 5; ra1_e = 5;
        #1 chk("fwd_a_mem", 32'(if_a.fwd_a_e), 32'd2);
        reg_write_m = 0;
        #1 chk("fwd_a_wb", 32'(if_a.fwd_a_e), 32'd1);
        ra1_e = 0; reg_write_m = 1; write_reg_m = 0; write_reg_w = 0;
        #1 chk("fwd_a_r0", 32'(if_a.fwd_a_e), 32'd0);
        ra2_e = 7; write_reg_w = 7; write_reg_m = 3;
        #1 chk("fwd_b_wb", 32'(if_b.fwd_b_e), 32'd1);
        clr();

        // Load-use on r3 via source 2.
        @(negedge clk);
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 3; ra2_d = 3; uses_ra2_d = 1;
        #1;
        chk("lu_stall_f", 32'(if_a.stall_f), 32'd1);
        chk("lu_stall_d", 32'(if_a.stall_d), 32'd1);
        chk("lu_flush_de", 32'(if_a.flush_de), 32'd1);
        chk("lu_stall_e", 32'(if_a.stall_e), 32'd0);
        chk("lu_flush_fd", 32'(if_a.flush_fd), 32'd0);
        tick();
        clr();
        #1;
        chk("lu_after_stall_d", 32'(if_a.stall_d), 32'd0);
        chk("lu_after_flush_de", 32'(if_a.flush_de), 32'd0);
        chk("lu_cnt_a", 32'(if_a.stall_cnt), 32'd1);
        // u_b: bubble then LOAD_LAT-1 full stalls.
        chk("lu_b_busy1", 32'(if_b.busy), 32'd1);
        chk("lu_b_stall_e1", 32'(if_b.stall_e), 32'd1);
        tick();
        chk("lu_b_busy2", 32'(if_b.busy), 32'd1);
        tick();
        chk("lu_b_idle", 32'(if_b.busy), 32'd0);
        chk("lu_b_cnt", 32'(if_b.stall_cnt), 32'd3);

        // Independent load on u_b, then branch during the wait.
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 4;
        #1;
        chk("ld_b_stall_e", 32'(if_b.stall_e), 32'd0);
        chk("ld_b_stall_d", 32'(if_b.stall_d), 32'd0);
        tick();
        clr();
        branch_taken_e = 1;
        #1;
        chk("mw_busy1", 32'(if_b.busy), 32'd1);
        chk("mw_flush_fd1", 32'(if_b.flush_fd), 32'd0);
        chk("mw_flush_de1", 32'(if_b.flush_de), 32'd0);
        tick();
        chk("mw_busy2", 32'(if_b.busy), 32'd1);
        chk("mw_flush_fd2", 32'(if_b.flush_fd), 32'd0);
        tick();
        chk("mw_end_busy", 32'(if_b.busy), 32'd0);
        chk("mw_end_flush_fd", 32'(if_b.flush_fd), 32'd1);
        chk("mw_end_flush_de", 32'(if_b.flush_de), 32'd1);
        chk("mw_end_stall_d", 32'(if_b.stall_d), 32'd0);

        // Load-use and branch together: branch wins.
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 3; ra1_d = 3; uses_ra1_d = 1;
        #1;
        chk("lub_flush_fd", 32'(if_a.flush_fd), 32'd1);
        chk("lub_flush_de", 32'(if_a.flush_de), 32'd1);
        chk("lub_stall_d", 32'(if_a.stall_d), 32'd0);
        chk("lub_stall_f", 32'(if_a.stall_f), 32'd0);
        tick();
        chk("pre_rst_busy_b", 32'(if_b.busy), 32'd1);

        // Asynchronous reset mid-wait.
        rst_n = 1'b0;
        #1;
        chk("arst_busy_b", 32'(if_b.busy), 32'd0);
        chk("arst_cnt_b", 32'(if_b.stall_cnt), 32'd0);
        chk("arst_cnt_a", 32'(if_a.stall_cnt), 32'd0);
        chk("arst_stall_e_b", 32'(if_b.stall_e), 32'd0);
        #1;
        rst_n = 1'b1;
        branch_taken_e = 0;

        // Held load-use on u_a: counter saturates at 3.
        tick();
        tick();
        tick();
        chk("sat_cnt3", 32'(if_a.stall_cnt), 32'd3);
        tick();
        tick();
        chk("sat_cnt5", 32'(if_a.stall_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It decides, every cycle, whether the decode-to-execute pipeline register loads, holds or clears, and it selects execute-stage operand forwarding. It also stretches the pipeline while a multi-cycle load occupies the memory stage. It consumes the register addresses and control bits that the decode/execute register presents, and it produces that register's clear (`FLUSH_DE`) and hold controls, plus the fetch/decode holds.

## Interface
- `LOAD_LAT`, default 2: memory-stage cycles per load. Must be ≥1; a value of 1 means single-cycle memory.
- `CNT_W`, default 16: width of the stall statistics counter.

- `CLK`  in  1  core clock; state updates on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `RA1_D`, `RA2_D`  in  5  source registers of the instruction in decode
- `USES_RA1_D`, `USES_RA2_D`  in  1  decode instruction actually reads that source
- `RA1_E`, `RA2_E`  in  5  source registers in execute
- `WRITE_REG_E`, `REG_WRITE_E`, `MEM_TO_REG_E`  in  5/1/1  execute destination, write enable, load flag
- `BRANCH_TAKEN_E`  in  1  branch/jump resolved taken in execute
- `WRITE_REG_M`, `REG_WRITE_M`  in  5/1  memory-stage destination and write enable
- `WRITE_REG_W`, `REG_WRITE_W`  in  5/1  writeback destination and write enable
- `STALL_F`, `STALL_D`, `STALL_E`  out  1  hold PC, fetch/decode register, decode/execute register
- `FLUSH_FD`, `FLUSH_DE`  out  1  clear fetch/decode register, decode/execute register
- `FWD_A_E`, `FWD_B_E`  out  2  operand select: 00 register file, 10 memory-stage ALU result, 01 writeback result
- `BUSY`  out  1  high while in MEM_WAIT
- `STALL_CNT`  out  CNT_W  saturating count of cycles with `STALL_D`=1

## Operation
- Register 0 never matches in any hazard or forwarding compare.
- Forwarding is combinational.
  - `FWD_A_E`=10 if `REG_WRITE_M` is high and `WRITE_REG_M` equals `RA1_E`.
  - Otherwise 01 if `REG_WRITE_W` is high and `WRITE_REG_W` equals `RA1_E`.
  - Otherwise 00.
  - The memory stage has priority. `FWD_B_E` uses the same rules with `RA2_E`.
- Load-use condition (LU):
  - `MEM_TO_REG_E` and `REG_WRITE_E` are both high, and
  - `WRITE_REG_E`≠0, and
  - `WRITE_REG_E` equals `RA1_D` with `USES_RA1_D` high, or equals `RA2_D` with `USES_RA2_D` high.
- FSM states: IDLE and MEM_WAIT, with a down-counter `cnt` of width $clog2(LOAD_LAT).
- IDLE outputs, applied in priority order:
  1. `BRANCH_TAKEN_E` high: `FLUSH_FD`=`FLUSH_DE`=1, all stalls 0. Branch overrides LU.
  2. Else LU: `STALL_F`=`STALL_D`=1, `FLUSH_DE`=1 (a bubble is inserted), `STALL_E`=0.
  3. Else all stall/flush outputs 0.
- IDLE to MEM_WAIT: on the rising edge where all of the following hold:
  - `LOAD_LAT`>1, and
  - `MEM_TO_REG_E` and `REG_WRITE_E` are high, and
  - `STALL_E`=0.
  - The load enters memory on that edge; `cnt` loads `LOAD_LAT`-1.
- MEM_WAIT outputs: `STALL_F`=`STALL_D`=`STALL_E`=1, flushes 0, `BUSY`=1.
  - `BRANCH_TAKEN_E` and LU are ignored. The instruction in E is held and re-evaluated once the FSM returns to IDLE.
- MEM_WAIT to IDLE: when `cnt`=1 at a rising edge. Otherwise `cnt` decrements.
- `STALL_CNT` increments on each rising edge with `STALL_D`=1 and saturates at all-ones.

## Timing
- Pipeline registers capture on the falling edge of `CLK`. All outputs must therefore be valid from rising-edge state within half a cycle. Outputs are combinational from state and inputs, with no added latency.
- A LU stall lasts exactly 1 cycle, unless the load also triggers MEM_WAIT. In that case the LU bubble cycle is followed by `LOAD_LAT`-1 full-stall cycles.
- A load with `LOAD_LAT`=N yields N-1 consecutive `BUSY` cycles.
- Reset (`RST_N` low, asynchronous):
  - State becomes IDLE, `cnt`=0, `STALL_CNT`=0.
  - While reset is held: all stall/flush outputs are 0, `FWD_A_E`=`FWD_B_E`=00, `BUSY`=0.
  - Reset asserted mid-MEM_WAIT aborts the wait immediately.
- Release of `RST_N` takes effect at the first rising edge after deassertion.

## Test plan
- ALU write to r5 in M while E reads `RA1_E`=5; in the same cycle W writes r5 -> `FWD_A_E`=10. With M not writing, the same setup gives `FWD_A_E`=01. With `RA1_E`=0 and M writing r0, the result is 00.
- Load to r3 in E while D reads r3 with `USES_RA2_D`=1, `LOAD_LAT`=1 -> one cycle of `STALL_F`=`STALL_D`=`FLUSH_DE`=1, then all 0; `STALL_CNT`=1.
- `LOAD_LAT`=3, load in E with no dependency -> after the edge, `BUSY`=1 and all stalls 1 for exactly 2 cycles, then IDLE.
- In MEM_WAIT, assert `BRANCH_TAKEN_E` -> no flush during the wait. `FLUSH_FD`=`FLUSH_DE`=1 in the first IDLE cycle if the input is still high.
- LU and `BRANCH_TAKEN_E` together in IDLE -> `FLUSH_FD`=`FLUSH_DE`=1, `STALL_D`=0.
- Pulse `RST_N` low mid-MEM_WAIT -> `BUSY`=0 and `STALL_CNT`=0 immediately, without waiting for a clock edge. Saturation check with `CNT_W`=2: 5 stalled cycles leave `STALL_CNT`=3.
